// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared definitions for the I2C receive-only target.
//   LCD_ADDR        : default 7-bit address this target answers (0x72).
//   ACK_BIT/NACK_BIT: value placed on SDA in the 9th clock of a byte.
//   RW_WRITE        : R/W bit value for a master-to-target transfer.
//   i2c_rx_state_t  : protocol FSM states.
package i2c_pkg;

    localparam logic [6:0] LCD_ADDR = 7'h72;

    localparam logic ACK_BIT  = 1'b0;
    localparam logic NACK_BIT = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_rx_state_t;

endpackage

// File: rtl/i2c_target_rx_if.sv
// i2c_target_rx_if -- received-byte handshake between the I2C target and
// its consumer.
//   rx_data    : byte at FIFO head (undefined when rx_valid=0)
//   rx_valid   : FIFO not empty
//   rx_pop     : consumer removes the head byte
//   addressed  : target selected (address ACK until STOP/START/reset)
//   frame_done : one-cycle pulse on STOP ending an addressed frame
//   overflow   : one-cycle pulse when a data byte is NACKed for lack of room
// Modports: slave = the target block, master = the byte consumer.
interface i2c_target_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_pop;
    logic       addressed;
    logic       frame_done;
    logic       overflow;

    modport slave (
        output rx_data, rx_valid, addressed, frame_done, overflow,
        input  rx_pop
    );

    modport master (
        input  rx_data, rx_valid, addressed, frame_done, overflow,
        output rx_pop
    );

endinterface

// File: rtl/byte_fifo.sv
// byte_fifo -- small synchronous byte FIFO (first-word fall-through).
//   clock, reset : system clock, async active-high reset (empties the FIFO)
//   push         : write push_data when not full (refused when full)
//   pop          : drop head byte when not empty (ignored when empty)
//   pop_data     : head byte, valid while empty=0
//   empty, full  : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] pop_data,
    output logic       empty,
    output logic       full
);

    localparam int              AW         = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // Full is judged on the count before any same-cycle pop.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: the storage array has no reset; count and pointers alone decide
    // which entries are valid, so clearing them empties the FIFO.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i2c_target_rx.sv
// i2c_target_rx -- receive-only I2C target. Answers write transfers to
// TARGET_ADDR, ACKs each data byte while there is room and buffers it in a
// FIFO_DEPTH-entry byte FIFO; reads and other addresses are NACKed.
//   clock, reset : system clock, async active-high reset
//   scl          : bus clock (input only, never driven)
//   sda          : bus data, open drain (driven 0 or z)
//   rx           : received-byte handshake and status (slave modport)
module i2c_target_rx
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = LCD_ADDR,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic            clock,
    input  logic            reset,
    inout  tri1             scl,
    inout  tri1             sda,
    i2c_target_rx_if.slave  rx
);

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, start_det, stop_det;

    i2c_rx_state_t state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          sda_bit, sda_bit_n;
    logic          addressed, addressed_n;
    logic          frame_done, frame_done_n;
    logic          overflow, overflow_n;

    logic          fifo_push, fifo_empty, fifo_full;
    logic [7:0]    fifo_data;

    // Open drain: only an ACK pulls the line low.
    assign sda = (sda_bit == ACK_BIT) ? 1'b0 : 1'bz;

    // NOTE: registers take non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour, which is what makes this a chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s && !scl_d;
    assign scl_fall  = !scl_s && scl_d;
    assign start_det = scl_s && sda_d && !sda_s;
    assign stop_det  = scl_s && !sda_d && sda_s;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shift      <= '0;
            sda_bit    <= NACK_BIT;
            addressed  <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            sda_bit    <= sda_bit_n;
            addressed  <= addressed_n;
            frame_done <= frame_done_n;
            overflow   <= overflow_n;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        sda_bit_n    = sda_bit;
        addressed_n  = addressed;
        frame_done_n = 1'b0;
        overflow_n   = 1'b0;
        fifo_push    = 1'b0;

        if (stop_det) begin
            state_n      = IDLE;
            sda_bit_n    = NACK_BIT;
            addressed_n  = 1'b0;
            frame_done_n = addressed;
        end else if (start_det) begin
            // Also covers repeated START mid-frame.
            state_n     = ADDR;
            bit_cnt_n   = '0;
            sda_bit_n   = NACK_BIT;
            addressed_n = 1'b0;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // ACK is driven only while SCL is low, so SDA never
                        // moves during an SCL high phase.
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == TARGET_ADDR && shift[0] == RW_WRITE) begin
                                state_n     = ADDR_ACK;
                                sda_bit_n   = ACK_BIT;
                                addressed_n = 1'b1;
                            end else begin
                                state_n = IGNORE;
                            end
                        end else begin
                            state_n = DATA_ACK;
                            if (fifo_full) begin
                                overflow_n = 1'b1;
                            end else begin
                                fifo_push = 1'b1;
                                sda_bit_n = ACK_BIT;
                            end
                        end
                    end
                end
                ADDR_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                        sda_bit_n = NACK_BIT;
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for START/STOP only.
                end
            endcase
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (shift),
        .pop       (rx.rx_pop),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign rx.rx_data    = fifo_data;
    assign rx.rx_valid   = !fifo_empty;
    assign rx.addressed  = addressed;
    assign rx.frame_done = frame_done;
    assign rx.overflow   = overflow;

endmodule

// File: tb/tb_i2c_target_rx.sv
// tb_i2c_target_rx -- self-checking bench for i2c_target_rx.
// A bit-banged I2C master drives scl/sda open drain; per-byte ACK
// expectations come from a vector table, accepted bytes are pushed to a
// scoreboard queue and compared as the consumer pops them. Monitors count
// pulses, addressed cycles and cycles in which the target pulls SDA low.
module tb_i2c_target_rx;

    localparam int QTR = 4;   // system clocks per quarter SCL period

    typedef struct {
        logic [7:0] data;
        logic       exp_ack;
        logic       exp_push;
    } vec_t;

    logic clock;
    logic reset;
    logic m_scl_low;
    logic m_sda_low;
    tri1  scl;
    tri1  sda;

    i2c_target_rx_if rx_if ();

    assign scl = m_scl_low ? 1'b0 : 1'bz;
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    i2c_target_rx #(
        .TARGET_ADDR (7'h72),
        .FIFO_DEPTH  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .scl   (scl),
        .sda   (sda),
        .rx    (rx_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    vec_t vecs [0:10];

    // Monitors: counters only, read by the main sequence as differences.
    int   fd_cnt = 0, ov_cnt = 0, addr_cnt = 0, valid_cnt = 0;
    int   dut_low_cnt = 0, hold_viol = 0;
    logic scl_q = 1'b1, sda_q = 1'b1, dut_low_q = 1'b0;

    always @(posedge clock) begin
        if (rx_if.frame_done === 1'b1) fd_cnt++;
        if (rx_if.overflow === 1'b1)   ov_cnt++;
        if (rx_if.addressed === 1'b1)  addr_cnt++;
        if (rx_if.rx_valid === 1'b1)   valid_cnt++;
        if (!m_sda_low && sda === 1'b0) dut_low_cnt++;
        // Target-held SDA must stay put while SCL is high (reset excepted).
        if (!reset && dut_low_q && scl_q === 1'b1 && scl === 1'b1 && sda !== sda_q)
            hold_viol++;
        scl_q     <= scl;
        sda_q     <= sda;
        dut_low_q <= !m_sda_low && sda === 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (QTR) @(negedge clock);
    endtask

    task automatic bus_start();
        m_sda_low = 1'b1; wait_q();
        m_scl_low = 1'b1; wait_q();
    endtask

    task automatic bus_rstart();
        m_sda_low = 1'b0; wait_q();
        m_scl_low = 1'b0; wait_q();
        m_sda_low = 1'b1; wait_q();
        m_scl_low = 1'b1; wait_q();
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; wait_q();
        m_scl_low = 1'b0; wait_q();
        m_sda_low = 1'b0; wait_q();
        wait_q();
    endtask

    // Sends one byte plus the 9th clock; optionally asserts reset while SCL
    // is high in the 9th clock.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack,
                             input logic exp_push, input bit rst_in_ack);
        logic ack;
        for (int i = 7; i >= 0; i--) begin
            m_sda_low = ~b[i]; wait_q();
            m_scl_low = 1'b0;  wait_q(); wait_q();
            m_scl_low = 1'b1;  wait_q();
        end
        if (exp_push) exp_q.push_back(b);
        m_sda_low = 1'b0; wait_q();
        m_scl_low = 1'b0; wait_q();
        ack = (sda === 1'b0);
        check($sformatf("ack_%02h", b), ack, exp_ack);
        if (rst_in_ack) begin
            reset = 1'b1;
            #1;
            check("rst_sda_released", sda, 1'b1);
            check("rst_rx_valid", rx_if.rx_valid, 1'b0);
            check("rst_addressed", rx_if.addressed, 1'b0);
            exp_q.delete();
            wait_q();
            reset = 1'b0;
        end
        wait_q();
        m_scl_low = 1'b1; wait_q();
    endtask

    task automatic run_table(input int lo, input int hi);
        bus_start();
        for (int i = lo; i <= hi; i++)
            send_byte(vecs[i].data, vecs[i].exp_ack, vecs[i].exp_push, 1'b0);
        bus_stop();
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            check({tag, "_valid"}, rx_if.rx_valid, 1'b1);
            check({tag, "_data"}, rx_if.rx_data, e);
            rx_if.rx_pop = 1'b1; @(negedge clock);
            rx_if.rx_pop = 1'b0; @(negedge clock);
        end
        check({tag, "_empty"}, rx_if.rx_valid, 1'b0);
    endtask

    initial begin
        int fd0, ov0, ad0, va0, dl0;

        // Good frame: address write + two data bytes.
        vecs[0]  = '{8'hE4, 1'b1, 1'b0};
        vecs[1]  = '{8'h7C, 1'b1, 1'b1};
        vecs[2]  = '{8'h2D, 1'b1, 1'b1};
        // Wrong address 0x73: everything NACKed.
        vecs[3]  = '{8'hE6, 1'b0, 1'b0};
        vecs[4]  = '{8'h48, 1'b0, 1'b0};
        // "HELLO" into a 4-deep FIFO with no pops.
        vecs[5]  = '{8'hE4, 1'b1, 1'b0};
        vecs[6]  = '{8'h48, 1'b1, 1'b1};
        vecs[7]  = '{8'h45, 1'b1, 1'b1};
        vecs[8]  = '{8'h4C, 1'b1, 1'b1};
        vecs[9]  = '{8'h4C, 1'b1, 1'b1};
        vecs[10] = '{8'h4F, 1'b0, 1'b0};

        reset = 1'b1;
        m_scl_low = 1'b0;
        m_sda_low = 1'b0;
        rx_if.rx_pop = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rx_valid", rx_if.rx_valid, 1'b0);
        check("reset_addressed", rx_if.addressed, 1'b0);
        check("reset_frame_done", rx_if.frame_done, 1'b0);
        check("reset_overflow", rx_if.overflow, 1'b0);
        check("reset_sda", sda, 1'b1);
        reset = 1'b0;
        wait_q();

        // Good frame.
        fd0 = fd_cnt; ad0 = addr_cnt;
        run_table(0, 2);
        check("a_frame_done", fd_cnt - fd0, 1);
        check("a_addressed_seen", addr_cnt > ad0, 1'b1);
        check("a_addressed_after_stop", rx_if.addressed, 1'b0);
        drain("a");

        // Wrong address.
        fd0 = fd_cnt; ad0 = addr_cnt; va0 = valid_cnt; dl0 = dut_low_cnt;
        run_table(3, 4);
        check("b_sda_never_driven", dut_low_cnt - dl0, 0);
        check("b_rx_valid_cycles", valid_cnt - va0, 0);
        check("b_addressed_cycles", addr_cnt - ad0, 0);
        check("b_frame_done", fd_cnt - fd0, 0);

        // Read request to our address: NACK, then ignored until STOP.
        ad0 = addr_cnt; va0 = valid_cnt; dl0 = dut_low_cnt;
        bus_start();
        send_byte(8'hE5, 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b0, 1'b0, 1'b0);
        bus_stop();
        check("c_sda_never_driven", dut_low_cnt - dl0, 0);
        check("c_addressed_cycles", addr_cnt - ad0, 0);
        check("c_rx_valid_cycles", valid_cnt - va0, 0);

        // Overflow on the fifth byte.
        ov0 = ov_cnt; fd0 = fd_cnt;
        run_table(5, 10);
        check("d_overflow_pulses", ov_cnt - ov0, 1);
        check("d_frame_done", fd_cnt - fd0, 1);
        drain("d");

        // Repeated START between two addressed frames.
        fd0 = fd_cnt;
        bus_start();
        send_byte(8'hE4, 1'b1, 1'b0, 1'b0);
        send_byte(8'h2D, 1'b1, 1'b1, 1'b0);
        bus_rstart();
        send_byte(8'hE4, 1'b1, 1'b0, 1'b0);
        send_byte(8'h7C, 1'b1, 1'b1, 1'b0);
        bus_stop();
        check("e_frame_done", fd_cnt - fd0, 1);
        drain("e");

        // Reset during the 9th clock of an address ACK.
        bus_start();
        send_byte(8'hE4, 1'b1, 1'b0, 1'b0);
        send_byte(8'h55, 1'b1, 1'b1, 1'b0);
        check("f_valid_before_reset", rx_if.rx_valid, 1'b1);
        bus_rstart();
        send_byte(8'hE4, 1'b1, 1'b0, 1'b1);
        m_scl_low = 1'b0;
        wait_q();
        bus_start();
        send_byte(8'hE4, 1'b1, 1'b0, 1'b0);
        send_byte(8'h99, 1'b1, 1'b1, 1'b0);
        bus_stop();
        drain("f");

        check("sda_hold_while_scl_high", hold_viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h72, is the 7-bit address this target answers.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of two, 2..16), is the received-byte buffer depth.
REQ-003 Port clock, input, 1: the single system clock, rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port scl, inout tri1, 1: bus clock; this block never drives it.
REQ-006 Port sda, inout tri1, 1: bus data; this block drives only 0 or z (open drain).
REQ-007 Port rx_data, output, 8: byte at FIFO head; undefined when rx_valid=0.
REQ-008 Port rx_valid, output, 1: FIFO not empty.
REQ-009 Port rx_pop, input, 1: removes the head byte when rx_valid=1; ignored when empty.
REQ-010 Port addressed, output, 1: high from the matching address ACK until STOP, START or reset.
REQ-011 Port frame_done, output, 1: one-cycle pulse on STOP that ends an addressed frame.
REQ-012 Port overflow, output, 1: one-cycle pulse when a data byte is NACKed because the FIFO is full.

Function
REQ-013 scl and sda pass through 2-flop synchronizers; all protocol decisions use the synchronized values plus one delay flop for edge detection.
REQ-014 START is sync SDA falling while sync SCL is high; STOP is sync SDA rising while sync SCL is high.
REQ-015 FSM states are IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-016 START from any state goes to ADDR, clears the bit counter and addressed, and releases sda; this covers repeated START.
REQ-017 STOP from any state goes to IDLE and releases sda; frame_done pulses if addressed was 1.
REQ-018 ADDR and DATA shift in SDA MSB-first on each sync SCL rising edge; 8 bits form a byte.
REQ-019 After the 8th address bit, on the SCL falling edge:
- addr[7:1]==TARGET_ADDR and R/W bit==0: go to ADDR_ACK, drive sda low.
- otherwise: go to IGNORE, leave sda released.
REQ-020 Read requests (R/W=1) are NACKed; this block is receive-only.
REQ-021 After the 8th data bit, on the SCL falling edge:
- FIFO not full: push the byte, go to DATA_ACK, drive sda low.
- FIFO full: drop the byte, pulse overflow, go to DATA_ACK with sda released (NACK).
REQ-022 ACK/NACK state ends on the next SCL falling edge (end of the 9th clock): sda is released and the FSM goes to DATA.
REQ-023 IGNORE ignores all SCL/SDA activity except START and STOP.
REQ-024 A pushed byte is visible on rx_valid/rx_data on the clock cycle after the push.
REQ-025 Full is evaluated before any same-cycle pop; simultaneous push and pop on a non-full FIFO keeps the count unchanged.
REQ-026 FIFO pointers wrap modulo FIFO_DEPTH, and the count is one bit wider than the pointers.
REQ-027 SDA must not change while this block drives it low during an SCL high phase.
REQ-028 Bytes already in the FIFO survive START, STOP and NACK; only reset clears them.

Reset
REQ-029 Reset puts the FSM in IDLE and clears the synchronizers (to 1), bit counter and FIFO.
REQ-030 Reset drives rx_valid=0, addressed=0, frame_done=0, overflow=0 and sda released, immediately and asynchronously.
REQ-031 Reset asserted mid-byte or mid-ACK releases sda at once; after deassertion the block waits in IDLE for a new START.

Structure
REQ-032 Package i2c_pkg holds:
- the LCD_ADDR constant (7'h72),
- the i2c_rx_state_t enum,
- the ACK/NACK bit constants.
REQ-033 The FIFO is one sub-module, byte_fifo: parameter DEPTH; ports clock, reset, push, push_data, pop, pop_data, empty, full.

Verification
REQ-034 Bench master sends START, 0xE4, 0x7C, 0x2D, STOP; expected response:
- three ACKs;
- rx_data pops 0x7C then 0x2D;
- frame_done pulses once.
REQ-035 Bench master sends START, 0xE6 (address 0x73), 0x48, STOP; expected response:
- NACK on the address and on 0x48 (sda never driven);
- rx_valid stays 0;
- addressed stays 0.
REQ-036 Bench master sends START, 0xE5 (read of 0x72); expected response: NACK, FSM in IGNORE until STOP.
REQ-037 Bench sends "HELLO" (0x48 0x45 0x4C 0x4C 0x4F) with FIFO_DEPTH=4 and no pops; expected response:
- first four bytes ACKed;
- 0x4F NACKed with one overflow pulse;
- FIFO holds 0x48..0x4C.
REQ-038 Bench sends START, 0xE4, 0x2D, repeated START, 0xE4, 0x7C, STOP; expected response: both frames ACKed and FIFO holds 0x2D, 0x7C.
REQ-039 Bench asserts reset during the 9th clock of the address ACK; expected response:
- sda is released in the same cycle;
- rx_valid=0;
- the next START with 0xE4 is ACKed normally.
